csel_adder_pipe: RTL

//  Parametrised, pipelined carry-select adder/subtractor for the Booth multiplier's final CPA and other wide adds.
//  The operand width is split into BLK-bit segments; each segment computes its sum for cin=0 and cin=1 in parallel, and the real carry selects one.
//  The segment chain is cut into STAGES register stages under a valid/ready handshake.

---
 rtl/csel_adder_pipe_pkg.sv | 36 +++
 rtl/csel_adder_pipe_segment.sv | 29 ++
 rtl/csel_adder_pipe.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/csel_adder_pipe_pkg.sv
// Shared definitions for the pipelined carry-select adder.
//   ADD_MODE_*  : encoding of the in_sub control bit
//   DEFAULT_BLK : default segment width (one 4-bit CLA segment)
//   calc_sps()  : segments resolved per pipeline stage
//   params_ok() : legality of a WIDTH/BLK/STAGES combination
package csel_adder_pipe_pkg;

    localparam logic ADD_MODE_ADD = 1'b0;
    localparam logic ADD_MODE_SUB = 1'b1;

    localparam int unsigned DEFAULT_BLK = 4;

    // Segments per stage. Clamped to 1 so that an illegal parameter set still
    // elaborates far enough for the legality check to report it.
    function automatic int unsigned calc_sps(input int unsigned width,
                                             input int unsigned blk,
                                             input int unsigned stages);
        if ((blk == 0) || (stages == 0)) begin
            return 1;
        end
        if ((width / blk / stages) == 0) begin
            return 1;
        end
        return width / blk / stages;
    endfunction

    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned blk,
                                     input int unsigned stages);
        if ((blk == 0) || (stages == 0) || (width < blk)) begin
            return 1'b0;
        end
        return ((width % blk) == 0) && (((width / blk) % stages) == 0);
    endfunction

endpackage

// File: rtl/csel_adder_pipe_segment.sv
// One carry-select segment of BLK bits.
// Two adders run in parallel, one assuming carry-in 0 and one assuming
// carry-in 1; the real incoming carry (cin_sel) picks the result. Each adder
// is a plain BLK-bit add that synthesis maps to a carry-lookahead block.
// Ports:
//   a, b     in   BLK  segment operands (b already inverted for subtract)
//   cin_sel  in   1    carry from the previous segment
//   s        out  BLK  selected segment sum
//   cout     out  1    selected segment carry-out
module csel_adder_pipe_segment #(
    parameter int unsigned BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin_sel,
    output logic [BLK-1:0] s,
    output logic           cout
);

    logic [BLK:0] sum0;
    logic [BLK:0] sum1;

    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

    assign s    = cin_sel ? sum1[BLK-1:0] : sum0[BLK-1:0];
    assign cout = cin_sel ? sum1[BLK]     : sum0[BLK];

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor.
// The operands are split into WIDTH/BLK segments; the segment chain is cut
// into STAGES register stages, each stage resolving SPS consecutive
// segments using the carry handed over by the previous stage. All stages
// advance together under a single valid/ready handshake.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready = pipe can advance)
//   in_sub               0: a + b + cin, 1: a - b
//   in_a, in_b, in_cin   operands and carry-in (carry-in used in add mode)
//   out_valid/out_ready  result handshake
//   out_res              result modulo 2^WIDTH
//   out_cout             carry-out of the MSB (subtract: 1 = no borrow)
//   out_ovf              two's-complement signed overflow
module csel_adder_pipe
    import csel_adder_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned BLK    = DEFAULT_BLK,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned NSEG = (BLK == 0) ? 1 : WIDTH / BLK;
    localparam int unsigned SPS  = calc_sps(WIDTH, BLK, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if (!params_ok(WIDTH, BLK, STAGES)) begin : g_param_check
        $error("csel_adder_pipe: WIDTH must be a multiple of BLK and WIDTH/BLK of STAGES");
    end

    // ------------------------------------------------------------------
    // Operand preparation
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    always_comb begin
        b_eff = in_b;
        c0    = in_cin;
        case (in_sub)
            ADD_MODE_ADD: begin
                b_eff = in_b;
                c0    = in_cin;
            end
            ADD_MODE_SUB: begin
                b_eff = ~in_b;
                c0    = 1'b1;
            end
            default: begin
                b_eff = in_b;
                c0    = in_cin;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];

    // Stage inputs (previous register or prepared operands) and next values
    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_cout;
    logic [WIDTH-1:0]  st_a    [STAGES];
    logic [WIDTH-1:0]  st_b    [STAGES];
    logic [WIDTH-1:0]  st_res  [STAGES];
    logic [WIDTH-1:0]  res_nxt [STAGES];

    // Every segment's selected sum; each stage only keeps its own slice.
    logic [WIDTH-1:0]  sum_all;

    logic adv;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned LO = s * SPS * BLK;
        localparam int unsigned HI = (s + 1) * SPS * BLK;
        localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
        // Bits [HI-1:LO] set: the result bits this stage resolves.
        localparam logic [WIDTH-1:0] MASK =
            ({WIDTH{1'b1}} >> (WIDTH - HI)) & ~((ONE << LO) - ONE);

        if (s == 0) begin : g_head
            assign st_valid[s] = in_valid;
            assign st_c[s]     = c0;
            assign st_a[s]     = in_a;
            assign st_b[s]     = b_eff;
            assign st_res[s]   = '0;
        end else begin : g_body
            assign st_valid[s] = valid_q[s-1];
            assign st_c[s]     = carry_q[s-1];
            assign st_a[s]     = a_q[s-1];
            assign st_b[s]     = b_q[s-1];
            assign st_res[s]   = res_q[s-1];
        end

        assign res_nxt[s] = (st_res[s] & ~MASK) | (sum_all & MASK);
    end

    // ------------------------------------------------------------------
    // Segment chain
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int unsigned STG = k / SPS;

        logic           cin_sel;
        logic [BLK-1:0] sum;
        logic           cout;

        // The first segment of a stage takes the carry handed over by the
        // previous stage; the rest chain within the stage.
        if ((k % SPS) == 0) begin : g_first
            assign cin_sel = st_c[STG];
        end else begin : g_chain
            assign cin_sel = g_seg[k-1].cout;
        end

        csel_adder_pipe_segment #(
            .BLK (BLK)
        ) u_seg (
            .a       (st_a[STG][k*BLK +: BLK]),
            .b       (st_b[STG][k*BLK +: BLK]),
            .cin_sel (cin_sel),
            .s       (sum),
            .cout    (cout)
        );

        assign sum_all[k*BLK +: BLK] = sum;

        if ((k % SPS) == (SPS - 1)) begin : g_stage_cout
            assign st_cout[STG] = cout;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline advance: every stage shifts together, bubbles included.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                res_q[s] <= '0;
            end
        end else if (adv) begin
            valid_q <= st_valid;
            carry_q <= st_cout;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= st_a[s];
                b_q[s]   <= st_b[s];
                res_q[s] <= res_nxt[s];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = valid_q[LAST];
    assign out_res   = res_q[LAST];
    assign out_cout  = carry_q[LAST];
    // Same-sign operands producing a result of the opposite sign.
    assign out_ovf   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                       (res_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
